// File: rtl/pci_rr_arbiter.sv
// Central round-robin arbiter for a three-master PCI-style bus.
// Tracks bus ownership from Frame/IRDY and drives registered active-low grants.
module pci_rr_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req_A,
    input  logic       Req_B,
    input  logic       Req_C,
    input  logic       Frame,
    input  logic       IRDY,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       GNT_C,
    output logic [1:0] Owner,
    output logic       Bus_Idle
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam logic [1:0] M_A = 2'd0;
    localparam logic [1:0] M_B = 2'd1;
    localparam logic [1:0] M_C = 2'd2;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [1:0] holder_r;
    logic [1:0] holder_nxt_s;
    logic [1:0] last_r;
    logic [1:0] last_nxt_s;
    logic [7:0] timer_r;
    logic [7:0] timer_nxt_s;
    logic [7:0] timer_inc_s;
    logic       gnt_a_r;
    logic       gnt_b_r;
    logic       gnt_c_r;
    logic [1:0] owner_r;
    logic       bus_idle_r;

    logic [2:0] req_s;
    logic       idle_s;
    logic       frame_low_s;
    logic       any_req_s;
    logic       holder_req_s;
    logic       others_req_s;
    logic       holds_s;
    logic [1:0] winner_s;

    function automatic logic [1:0] next_master(input logic [1:0] m);
        logic [1:0] n;
        case (m)
            M_A:     n = M_B;
            M_B:     n = M_C;
            default: n = M_A;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] master_mask(input logic [1:0] m);
        logic [2:0] mask;
        case (m)
            M_A:     mask = 3'b001;
            M_B:     mask = 3'b010;
            default: mask = 3'b100;
        endcase
        return mask;
    endfunction

    // Search Last+1, Last+2, then Last itself.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] pick;
        c1 = next_master(last);
        c2 = next_master(c1);
        if ((req & master_mask(c1)) != 3'b000) begin
            pick = c1;
        end else if ((req & master_mask(c2)) != 3'b000) begin
            pick = c2;
        end else begin
            pick = last;
        end
        return pick;
    endfunction

    // Only a solid 0 counts as asserted on any of the shared active-low lines.
    assign req_s        = {(Req_C === 1'b0), (Req_B === 1'b0), (Req_A === 1'b0)};
    assign frame_low_s  = (Frame === 1'b0);
    assign idle_s       = (Frame !== 1'b0) && (IRDY !== 1'b0);
    assign any_req_s    = (req_s != 3'b000);
    assign holder_req_s = ((req_s & master_mask(holder_r)) != 3'b000);
    assign others_req_s = ((req_s & ~master_mask(holder_r)) != 3'b000);
    assign winner_s     = rr_pick(last_r, req_s);
    assign timer_inc_s  = (timer_r == 8'hFF) ? timer_r : (timer_r + 8'd1);

    // Next-state, grant holder, round-robin pointer and grant timer selection.
    always_comb begin
        state_nxt_s  = state_r;
        holder_nxt_s = holder_r;
        last_nxt_s   = last_r;
        timer_nxt_s  = timer_r;
        case (state_r)
            S_IDLE, S_TURN: begin
                if (idle_s && any_req_s) begin
                    state_nxt_s  = S_GRANT;
                    holder_nxt_s = winner_s;
                    last_nxt_s   = winner_s;
                    timer_nxt_s  = 8'd0;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_GRANT: begin
                if (frame_low_s) begin
                    state_nxt_s = S_BUSY;
                end else if (!holder_req_s || (timer_r == TIMER_LAST)) begin
                    state_nxt_s = S_TURN;
                end else begin
                    timer_nxt_s = timer_inc_s;
                end
            end
            S_BUSY: begin
                if (idle_s) begin
                    if (holder_req_s && !others_req_s) begin
                        state_nxt_s = S_GRANT;
                        timer_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = S_TURN;
                    end
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign holds_s = (state_nxt_s == S_GRANT) || (state_nxt_s == S_BUSY);

    // State and registered outputs, all derived from the next state so no input reaches a port combinationally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            holder_r   <= M_A;
            last_r     <= M_C;
            timer_r    <= 8'd0;
            gnt_a_r    <= 1'b1;
            gnt_b_r    <= 1'b1;
            gnt_c_r    <= 1'b1;
            owner_r    <= 2'd0;
            bus_idle_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            holder_r   <= holder_nxt_s;
            last_r     <= last_nxt_s;
            timer_r    <= timer_nxt_s;
            gnt_a_r    <= !(holds_s && (holder_nxt_s == M_A));
            gnt_b_r    <= !(holds_s && (holder_nxt_s == M_B));
            gnt_c_r    <= !(holds_s && (holder_nxt_s == M_C));
            owner_r    <= holds_s ? (holder_nxt_s + 2'd1) : 2'd0;
            bus_idle_r <= idle_s;
        end
    end

    assign GNT_A    = gnt_a_r;
    assign GNT_B    = gnt_b_r;
    assign GNT_C    = gnt_c_r;
    assign Owner    = owner_r;
    assign Bus_Idle = bus_idle_r;

endmodule
